// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer.
//   - seq_state_e : run-control state encoding (IDLE=0, RUN=1, HALTED=2, PAUSE=3)
//   - PhaseW      : width of the phase counter
//   - PhHaltChk   : the only phase on which a halt request is honoured
//   - PhLast      : final phase of an instruction (completion phase)
package phase_sequencer_pkg;

    localparam int unsigned PhaseW = 3;

    localparam logic [PhaseW-1:0] PhHaltChk = 3'd4;
    localparam logic [PhaseW-1:0] PhLast    = 3'd7;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2,
        StPause  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a look-ahead equality match.
// Ports:
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   clear    : synchronous clear to zero (wins over inc)
//   inc      : increment by one, holding at all-ones
//   count    : current count
//   match    : high when the value the counter would take on inc equals MatchVal
module sat_counter #(
    parameter int unsigned       Width    = 16,
    parameter logic [Width-1:0]  MatchVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] count,
    output logic             match
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_inc;
    logic             at_max;

    assign at_max    = &count_q;
    assign count_inc = at_max ? count_q : count_q + Width'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_inc;
        end
    end

    assign count = count_q;
    // Compare the post-increment value so the caller can act on the same edge
    // that records the completion.
    assign match = (count_inc == MatchVal);

endmodule

// File: rtl/phase_sequencer.sv
// Phase sequencer: steps the 3-bit instruction phase 0..7 for the CPU controller,
// handles start/halt run control, counts completed instructions and provides an
// optional instruction-count watchdog.
// Optional build macro: PHASE_SEQ_STEP_EN enables single-step (PAUSE state).
// Ports:
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   start       : run request, acted on in IDLE or HALTED
//   halt        : halt request, honoured only at phase 4 while running
//   step_mode   : pause after each instruction (step builds only)
//   step_req    : release one instruction from PAUSE (step builds only)
//   phase       : current phase 0..7
//   running     : state is RUN
//   halted      : state is HALTED
//   timeout     : sticky watchdog flag, cleared by start or rst
//   instr_done  : high on the phase-7 cycle while running
//   instr_count : saturating count of completed instructions
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              step_mode,
    input  logic              step_req,
    output logic [2:0]        phase,
    output logic              running,
    output logic              halted,
    output logic              timeout,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [CNT_W-1:0] MaxInstr = CNT_W'(MAX_INSTR);
    localparam bit               WdEn     = (MAX_INSTR != 0);

    seq_state_e        state_q;
    logic [PhaseW-1:0] phase_q;
    logic              timeout_q;
    logic              complete;
    logic              halt_hit;
    logic              cnt_match;
    logic              wd_fire;

`ifndef PHASE_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step_mode ^ step_req;
`endif

    assign complete = (state_q == StRun) && (phase_q == PhLast);
    assign halt_hit = (state_q == StRun) && (phase_q == PhHaltChk) && halt;
    assign wd_fire  = WdEn && complete && cnt_match;

    sat_counter #(
        .Width    (CNT_W),
        .MatchVal (MaxInstr)
    ) u_instr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (complete),
        .count (instr_count),
        .match (cnt_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    phase_q <= '0;
                    if (start) begin
                        state_q   <= StRun;
                        timeout_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (halt_hit) begin
                        // Abandon the instruction: no completion is recorded.
                        state_q <= StHalted;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        if (wd_fire) begin
                            state_q   <= StHalted;
                            timeout_q <= 1'b1;
                        end
`ifdef PHASE_SEQ_STEP_EN
                        else if (complete && step_mode) begin
                            state_q <= StPause;
                        end
`endif
                    end
                end
                StHalted: begin
                    phase_q <= '0;
                    if (start) begin
                        state_q   <= StRun;
                        timeout_q <= 1'b0;
                    end
                end
                StPause: begin
                    phase_q <= '0;
`ifdef PHASE_SEQ_STEP_EN
                    if (step_req || !step_mode) begin
                        state_q <= StRun;
                    end
`else
                    // Unreachable without single-step; recover to IDLE.
                    state_q <= StIdle;
`endif
                end
                default: begin
                    state_q <= StIdle;
                    phase_q <= '0;
                end
            endcase
        end
    end

    assign phase      = phase_q;
    assign running    = (state_q == StRun);
    assign halted     = (state_q == StHalted);
    assign timeout    = timeout_q;
    assign instr_done = complete;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, halt = 1'b0, step_mode = 1'b0, step_req = 1'b0;
    logic start2 = 1'b0, start3 = 1'b0;

    logic [2:0]  phase, phase2, phase3;
    logic        running, halted, timeout, instr_done;
    logic        running2, halted2, timeout2, instr_done2;
    logic        running3, halted3, timeout3, instr_done3;
    logic [15:0] instr_count, instr_count2;
    logic [1:0]  instr_count3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.CNT_W(16), .MAX_INSTR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt),
        .step_mode(step_mode), .step_req(step_req),
        .phase(phase), .running(running), .halted(halted), .timeout(timeout),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    phase_sequencer #(.CNT_W(16), .MAX_INSTR(2)) dut_wd (
        .clk(clk), .rst(rst), .start(start2), .halt(1'b0),
        .step_mode(1'b0), .step_req(1'b0),
        .phase(phase2), .running(running2), .halted(halted2), .timeout(timeout2),
        .instr_done(instr_done2), .instr_count(instr_count2)
    );

    phase_sequencer #(.CNT_W(2), .MAX_INSTR(0)) dut_sat (
        .clk(clk), .rst(rst), .start(start3), .halt(1'b0),
        .step_mode(1'b0), .step_req(1'b0),
        .phase(phase3), .running(running3), .halted(halted3), .timeout(timeout3),
        .instr_done(instr_done3), .instr_count(instr_count3)
    );

    // Advance one clock and settle past the edge before sampling/driving.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", running); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", instr_done); end
        total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
        // IDLE holds phase at 0 without start
        tick(3);
        total++; if (phase !== 3'd0 || running !== 1'b0) begin
            bad++; $display("FAIL idle_hold phase=%0d running=%b exp 0/0", phase, running);
        end
    endtask

    task automatic test_run();
        logic [2:0] exp_ph;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            exp_ph = 3'(i % 8);
            total++; if (phase !== exp_ph || running !== 1'b1) begin
                bad++; $display("FAIL run_phase[%0d] phase=%0d running=%b exp %0d/1", i, phase, running, exp_ph);
            end
            total++; if (instr_done !== (exp_ph == 3'd7)) begin
                bad++; $display("FAIL run_done[%0d] got=%b exp=%b", i, instr_done, (exp_ph == 3'd7));
            end
            tick(1);
        end
        total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL run_count got=%0d exp=3", instr_count); end
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL run_wrap got=%0d exp=0", phase); end
    endtask

    task automatic test_halt_ignored();
        // Continues from test_run: RUN, phase 0, count 3. halt high except at phase 4.
        for (int i = 0; i < 8; i++) begin
            halt = (i != 4);
            tick(1);
        end
        halt = 1'b0;
        total++; if (running !== 1'b1 || halted !== 1'b0) begin
            bad++; $display("FAIL halt_ignored running=%b halted=%b exp 1/0", running, halted);
        end
        total++; if (instr_count !== 16'd4) begin bad++; $display("FAIL halt_ignored_count got=%0d exp=4", instr_count); end
        // start is ignored while running
        start = 1'b1;
        tick(3);
        start = 1'b0;
        total++; if (phase !== 3'd3) begin bad++; $display("FAIL run_start_ignored phase=%0d exp=3", phase); end
        tick(5);
    endtask

    task automatic test_reset_midrun();
        tick(5);
        total++; if (phase !== 3'd5) begin bad++; $display("FAIL pre_reset_phase got=%0d exp=5", phase); end
        rst = 1'b1;
        #1;
        total++; if (phase !== 3'd0 || running !== 1'b0) begin
            bad++; $display("FAIL async_reset phase=%0d running=%b exp 0/0", phase, running);
        end
        total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL async_reset_count got=%0d exp=0", instr_count); end
        #1;
        rst = 1'b0;
        tick(1);
        total++; if (running !== 1'b0 || instr_done !== 1'b0) begin
            bad++; $display("FAIL post_reset running=%b done=%b exp 0/0", running, instr_done);
        end
    endtask

    task automatic test_halt();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL halt_pre_count got=%0d exp=1", instr_count); end
        tick(4);
        total++; if (phase !== 3'd4) begin bad++; $display("FAIL halt_at4 phase=%0d exp=4", phase); end
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        total++; if (halted !== 1'b1 || running !== 1'b0) begin
            bad++; $display("FAIL halt_state halted=%b running=%b exp 1/0", halted, running);
        end
        total++; if (phase !== 3'd0) begin bad++; $display("FAIL halt_phase got=%0d exp=0", phase); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d exp=1", instr_count); end
        tick(4);
        total++; if (halted !== 1'b1 || phase !== 3'd0) begin
            bad++; $display("FAIL halt_hold halted=%b phase=%0d exp 1/0", halted, phase);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
        total++; if (running !== 1'b1 || halted !== 1'b0 || phase !== 3'd0) begin
            bad++; $display("FAIL resume running=%b halted=%b phase=%0d exp 1/0/0", running, halted, phase);
        end
        tick(1);
        total++; if (phase !== 3'd1) begin bad++; $display("FAIL resume_step phase=%0d exp=1", phase); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL resume_count got=%0d exp=1", instr_count); end
    endtask

    task automatic test_watchdog();
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(15);
        total++; if (phase2 !== 3'd7 || instr_done2 !== 1'b1 || timeout2 !== 1'b0) begin
            bad++; $display("FAIL wd_last phase=%0d done=%b timeout=%b exp 7/1/0", phase2, instr_done2, timeout2);
        end
        tick(1);
        total++; if (halted2 !== 1'b1 || timeout2 !== 1'b1) begin
            bad++; $display("FAIL wd_fire halted=%b timeout=%b exp 1/1", halted2, timeout2);
        end
        total++; if (instr_count2 !== 16'd2 || phase2 !== 3'd0) begin
            bad++; $display("FAIL wd_count count=%0d phase=%0d exp 2/0", instr_count2, phase2);
        end
        tick(3);
        total++; if (timeout2 !== 1'b1 || halted2 !== 1'b1) begin
            bad++; $display("FAIL wd_sticky timeout=%b halted=%b exp 1/1", timeout2, halted2);
        end
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        total++; if (timeout2 !== 1'b0 || running2 !== 1'b1) begin
            bad++; $display("FAIL wd_clear timeout=%b running=%b exp 0/1", timeout2, running2);
        end
        tick(8);
        total++; if (instr_count2 !== 16'd3 || running2 !== 1'b1) begin
            bad++; $display("FAIL wd_past count=%0d running=%b exp 3/1", instr_count2, running2);
        end
    endtask

    task automatic test_saturate();
        start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        tick(24);
        total++; if (instr_count3 !== 2'd3) begin bad++; $display("FAIL sat_reach got=%0d exp=3", instr_count3); end
        tick(16);
        total++; if (instr_count3 !== 2'd3 || running3 !== 1'b1) begin
            bad++; $display("FAIL sat_hold count=%0d running=%b exp 3/1", instr_count3, running3);
        end
    endtask

    task automatic test_step();
        do_reset();
        step_mode = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
`ifdef PHASE_SEQ_STEP_EN
        total++; if (running !== 1'b0 || halted !== 1'b0 || phase !== 3'd0) begin
            bad++; $display("FAIL step_pause running=%b halted=%b phase=%0d exp 0/0/0", running, halted, phase);
        end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL step_count1 got=%0d exp=1", instr_count); end
        tick(3);
        total++; if (running !== 1'b0 || phase !== 3'd0) begin
            bad++; $display("FAIL step_hold running=%b phase=%0d exp 0/0", running, phase);
        end
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        total++; if (running !== 1'b1 || phase !== 3'd0) begin
            bad++; $display("FAIL step_release running=%b phase=%0d exp 1/0", running, phase);
        end
        tick(7);
        total++; if (phase !== 3'd7 || instr_done !== 1'b1) begin
            bad++; $display("FAIL step_last phase=%0d done=%b exp 7/1", phase, instr_done);
        end
        tick(1);
        total++; if (running !== 1'b0 || instr_count !== 16'd2) begin
            bad++; $display("FAIL step_repause running=%b count=%0d exp 0/2", running, instr_count);
        end
        step_mode = 1'b0;
        tick(1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL step_exit running=%b exp=1", running); end
`else
        // Without single-step the step inputs have no effect.
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        total++; if (running !== 1'b1 || phase !== 3'd1) begin
            bad++; $display("FAIL step_ignored running=%b phase=%0d exp 1/1", running, phase);
        end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL step_ignored_count got=%0d exp=1", instr_count); end
`endif
        step_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        do_reset();
        test_reset();
        test_run();
        test_halt_ignored();
        test_reset_midrun();
        test_halt();
        do_reset();
        test_watchdog();
        test_saturate();
        test_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the 3-bit `phase` that drives the CPU controller. Each instruction runs through phases 0..7 in order.
- Run control: start, halt handling, and an optional instruction-count watchdog.
- Counts completed instructions.
- Sits directly upstream of the controller: `phase` feeds it, and its `halt` output returns here.

Parameters:
- CNT_W, 16: width of the instruction counter.
- MAX_INSTR, 0: watchdog limit in completed instructions; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  level-sampled request to run; acted on only in IDLE or HALTED.
- halt  input  1  halt request from the controller; honoured only when phase==4 and state RUN.
- step_mode  input  1  single-step enable (used only with PHASE_SEQ_STEP_EN).
- step_req  input  1  single-step release pulse (used only with PHASE_SEQ_STEP_EN).
- phase  output  3  current phase, 0..7.
- running  output  1  high while state is RUN.
- halted  output  1  high while state is HALTED.
- timeout  output  1  sticky; set when the watchdog fires, cleared by start or rst.
- instr_done  output  1  one-cycle pulse on the cycle phase==7 in RUN.
- instr_count  output  CNT_W  completed-instruction count.

Behaviour:
- Reset (async, immediate) values: phase=0, state=IDLE, running=0, halted=0, timeout=0, instr_done=0, instr_count=0. Reset mid-instruction aborts it with no completion pulse.
- States: IDLE, RUN, HALTED, PAUSE (PAUSE exists only with the macro). All outputs are registered or decoded from state/phase registers; no combinational input-to-output path.
- IDLE:
  - phase held at 0.
  - start=1 -> RUN next edge. First RUN cycle presents phase=0; phase increments each following edge.
- RUN:
  - phase <= phase+1 mod 8 every edge.
  - instr_done = (phase==7). instr_count increments on the 7->0 edge and saturates at all-ones (no wrap).
  - start is ignored.
- Halt:
  - Condition: halt=1 while phase==4 in RUN.
  - Next edge: state=HALTED, phase=0. The instruction is not counted and instr_done does not pulse.
  - halt at any other phase is ignored.
- HALTED:
  - phase held at 0.
  - start=1 -> RUN next edge. Clears timeout; instr_count is not cleared (only rst clears it).
- Watchdog (MAX_INSTR!=0):
  - Fires on the 7->0 edge on which the incremented count equals MAX_INSTR.
  - That edge: state -> HALTED, timeout -> 1. The completion is still counted and instr_done still pulses that cycle.
- Simultaneous halt and watchdog: impossible in the same cycle, since they occur at different phases.

Optional Feature:
- Macro: PHASE_SEQ_STEP_EN.
- With the macro:
  - If step_mode=1 on the 7->0 edge in RUN, state -> PAUSE instead of continuing; phase=0, running=0, halted=0.
  - In PAUSE, step_req=1 -> RUN for exactly one more instruction, then PAUSE again while step_mode remains 1.
  - step_mode=0 while in PAUSE -> RUN next edge.
  - Watchdog and halt take priority over entering PAUSE.
- Without the macro: step_mode and step_req ports are present but ignored; PAUSE is unreachable.

Decomposition:
- Shared package/header holds:
  - State encodings: IDLE=0, RUN=1, HALTED=2, PAUSE=3.
  - Phase constants: PH_HALT_CHK=4, PH_LAST=7.
  - Phase width: 3.
- One natural sub-module, sat_counter: parameterised saturating counter with inc, clear and an equality-match output. It is used for instr_count and the watchdog compare.

Test Plan:
- Reset during RUN at phase=5 -> phase=0, running=0, instr_count=0 asynchronously, before the next clock edge.
- start pulse in IDLE, no halt -> phase sequence 0,1,..,7,0; instr_done high on every phase==7 cycle; instr_count=3 after 24 RUN cycles.
- halt=1 at phase 4 on the 2nd instruction -> next cycle halted=1, phase=0, instr_count=1. A later start resumes RUN from phase 0.
- halt=1 held during phases 0-3 and 5-7 -> no effect; instr_count keeps incrementing.
- MAX_INSTR=2 -> halted=1 and timeout=1 after the 2nd instruction, instr_count=2. start clears timeout.
- PHASE_SEQ_STEP_EN with step_mode=1 -> PAUSE after each instruction. Each step_req pulse advances exactly 8 phases and increments instr_count by 1.
